// File: rtl/sha256_bridge_pkg.sv
// rtl/sha256_bridge_pkg.sv - shared states, constants and block-count helper for the SHA-256 host bridge
package sha256_bridge_pkg;

  typedef enum logic [2:0] {
    LOAD  = 3'd0,
    PAD   = 3'd1,
    START = 3'd2,
    HASH  = 3'd3,
    RD    = 3'd4,
    OUT   = 3'd5
  } state_e;

  localparam logic [31:0] PAD_WORD     = 32'h8000_0000;
  localparam int          DIGEST_WORDS = 8;

  // 512-bit blocks needed for n message words plus the 0x80 word and the 64-bit length
  function automatic int num_blocks(input int n);
    return (n + 2) / 16 + 1;
  endfunction

endpackage

// File: rtl/sha256_word_ram.sv
// rtl/sha256_word_ram.sv - single-port word RAM, synchronous write, registered read
module sha256_word_ram #(
  parameter int DEPTH = 2048
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);

  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_q;
  logic [31:0] rdata_d;

  // Read data only moves on a read cycle; writes leave the last read word in place.
  always_comb begin
    rdata_d = rdata_q;
    if (en && !we) rdata_d = mem[addr];
  end

  always_ff @(posedge clk) begin
    if (en && we) mem[addr] <= wdata;
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sha256_host_bridge.sv
// rtl/sha256_host_bridge.sv - host load/unload front end and memory responder for simplified_sha256
// Optional feature: SHA_BRIDGE_AUTOPAD_EN appends SHA-256 padding in hardware.
module sha256_host_bridge
  import sha256_bridge_pkg::*;
#(
  parameter int NUM_OF_WORDS = 40,
  parameter int DEPTH        = 2048,
  parameter int MSG_BASE     = 0,
  parameter int OUT_BASE     = 1000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        busy,
  output logic        error,
  output logic        sha_start,
  output logic [15:0] sha_message_addr,
  output logic [15:0] sha_output_addr,
  input  logic        sha_done,
  input  logic        sha_mem_we,
  input  logic [15:0] sha_mem_addr,
  input  logic [31:0] sha_mem_write_data,
  output logic [31:0] sha_mem_read_data
);

  localparam int          AW          = $clog2(DEPTH);
  localparam logic [16:0] DEPTH17     = 17'(DEPTH);
  localparam logic [15:0] MSG_BASE16  = 16'(MSG_BASE);
  localparam logic [15:0] OUT_BASE16  = 16'(OUT_BASE);
  localparam logic [15:0] BLOCK_WORDS = 16'(16 * num_blocks(NUM_OF_WORDS));
  localparam logic [15:0] LAST_DIGEST = 16'(DIGEST_WORDS - 1);
`ifdef SHA_BRIDGE_AUTOPAD_EN
  localparam logic [15:0] MSG_WORDS   = 16'(NUM_OF_WORDS);
  localparam logic [31:0] LEN_BITS    = 32'(NUM_OF_WORDS * 32);
  localparam logic [15:0] LOAD_WORDS  = MSG_WORDS;
`else
  localparam logic [15:0] LOAD_WORDS  = BLOCK_WORDS;
`endif

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;
  logic        out_last_q, out_last_d;
  logic        busy_q, busy_d;
  logic        error_q, error_d;
  logic        sha_start_q, sha_start_d;
  logic        hrd_q, hrd_d;
  logic [31:0] hold_q, hold_d;

  logic        ram_en, ram_we, sha_in_range;
  logic [15:0] addr16;
  logic [31:0] ram_wdata, ram_rdata;
  logic        unused_addr_hi;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    error_d      = error_q;
    hrd_d        = hrd_q;
    hold_d       = hold_q;
    ram_en       = 1'b0;
    ram_we       = 1'b0;
    addr16       = '0;
    ram_wdata    = '0;
    sha_in_range = ({1'b0, sha_mem_addr} < DEPTH17);

    case (state_q)
      LOAD: begin
        addr16    = MSG_BASE16 + cnt_q;
        ram_wdata = in_data;
        if (in_valid) begin
          ram_en = 1'b1;
          ram_we = 1'b1;
          cnt_d  = cnt_q + 16'd1;
          if (cnt_q == LOAD_WORDS - 16'd1) begin
`ifdef SHA_BRIDGE_AUTOPAD_EN
            state_d = PAD;
`else
            state_d = START;
            cnt_d   = '0;
`endif
          end
        end
      end
`ifdef SHA_BRIDGE_AUTOPAD_EN
      PAD: begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        addr16    = MSG_BASE16 + cnt_q;
        ram_wdata = (cnt_q == MSG_WORDS)            ? PAD_WORD :
                    (cnt_q == BLOCK_WORDS - 16'd1)  ? LEN_BITS : '0;
        cnt_d     = cnt_q + 16'd1;
        if (cnt_q == BLOCK_WORDS - 16'd1) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
`endif
      START, HASH: begin
        addr16    = sha_mem_addr;
        ram_we    = sha_mem_we;
        ram_wdata = sha_mem_write_data;
        ram_en    = sha_in_range;
        // hrd tracks whether the RAM read register currently holds the hasher's last read
        if (!sha_in_range) begin
          error_d = 1'b1;
          if (!sha_mem_we) begin
            hrd_d  = 1'b0;
            hold_d = '0;
          end
        end else if (!sha_mem_we) begin
          hrd_d = 1'b1;
        end
        if (state_q == START) begin
          cnt_d = cnt_q + 16'd1;
          if (cnt_q == 16'd1) begin
            state_d = HASH;
            cnt_d   = '0;
          end
        end else if (sha_done) begin
          state_d = RD;
          cnt_d   = '0;
        end
      end
      RD: begin
        ram_en  = 1'b1;
        addr16  = OUT_BASE16 + cnt_q;
        if (hrd_q) hold_d = ram_rdata;
        hrd_d   = 1'b0;
        state_d = OUT;
      end
      OUT: begin
        if (out_ready) begin
          if (cnt_q == LAST_DIGEST) begin
            state_d = LOAD;
            cnt_d   = '0;
          end else begin
            state_d = RD;
            cnt_d   = cnt_q + 16'd1;
          end
        end
      end
      default: begin
        state_d = LOAD;
        cnt_d   = '0;
      end
    endcase

    in_ready_d  = (state_d == LOAD);
    out_valid_d = (state_d == OUT);
    out_last_d  = (state_d == OUT) && (cnt_d == LAST_DIGEST);
    busy_d      = (state_d != LOAD);
    sha_start_d = (state_d == START);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= LOAD;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      error_q     <= 1'b0;
      sha_start_q <= 1'b0;
      hrd_q       <= 1'b0;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      error_q     <= error_d;
      sha_start_q <= sha_start_d;
      hrd_q       <= hrd_d;
      hold_q      <= hold_d;
    end
  end

  sha256_word_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .en    (ram_en && reset_n),
    .we    (ram_we),
    .addr  (addr16[AW-1:0]),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign unused_addr_hi    = ^addr16[15:AW];
  assign in_ready          = in_ready_q;
  assign out_valid         = out_valid_q;
  assign out_last          = out_last_q;
  assign out_data          = out_valid_q ? ram_rdata : '0;
  assign busy              = busy_q;
  assign error             = error_q;
  assign sha_start         = sha_start_q;
  assign sha_message_addr  = MSG_BASE16;
  assign sha_output_addr   = OUT_BASE16;
  assign sha_mem_read_data = hrd_q ? ram_rdata : hold_q;

endmodule

// File: tb/tb_sha256_host_bridge.sv
// tb/tb_sha256_host_bridge.sv - directed self-checking bench for sha256_host_bridge
module tb_sha256_host_bridge;

`ifdef SHA_BRIDGE_AUTOPAD_EN
  localparam int LOADN   = 40;
  localparam int EXP_LAT = 8;
`else
  localparam int LOADN   = 48;
  localparam int EXP_LAT = 0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;
  logic        error;
  logic        sha_start;
  logic [15:0] sha_message_addr;
  logic [15:0] sha_output_addr;
  logic        sha_done = 1'b0;
  logic        sha_mem_we = 1'b0;
  logic [15:0] sha_mem_addr = '0;
  logic [31:0] sha_mem_write_data = '0;
  logic [31:0] sha_mem_read_data;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  sha256_host_bridge dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .in_data            (in_data),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .out_data           (out_data),
    .out_last           (out_last),
    .busy               (busy),
    .error              (error),
    .sha_start          (sha_start),
    .sha_message_addr   (sha_message_addr),
    .sha_output_addr    (sha_output_addr),
    .sha_done           (sha_done),
    .sha_mem_we         (sha_mem_we),
    .sha_mem_addr       (sha_mem_addr),
    .sha_mem_write_data (sha_mem_write_data),
    .sha_mem_read_data  (sha_mem_read_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } hv_t;

  hv_t         tbl[$];
  logic [31:0] w [48];
  logic [31:0] dig [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic hv(input logic we, input logic [15:0] a, input logic [31:0] d,
                    input logic [31:0] er, input logic ee);
    hv_t v;
    v.we = we; v.addr = a; v.wdata = d; v.exp_rd = er; v.exp_err = ee;
    tbl.push_back(v);
  endtask

  task automatic load_and_start(input string tag);
    int n;
    for (int i = 0; i < LOADN; i++) begin
      chk($sformatf("%s in_ready[%0d]", tag, i), {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1;
      in_data  = w[i];
      step();
    end
    in_valid = 1'b0;
    chk({tag, " busy after load"}, {31'd0, busy}, 32'd1);
    chk({tag, " in_ready after load"}, {31'd0, in_ready}, 32'd0);
    n = 0;
    while (!sha_start && n < 20) begin
      step();
      n++;
    end
    chk({tag, " start latency"}, n, EXP_LAT);
    n = 0;
    while (sha_start && n < 10) begin
      n++;
      step();
    end
    chk({tag, " start width"}, n, 2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [31:0] held;

    w[0] = 32'h01234675;
    for (int i = 1; i < 40; i++) w[i] = {w[i-1][30:0], w[i-1][31]};
    w[40] = 32'h80000000;
    for (int i = 41; i < 47; i++) w[i] = 32'h0;
    w[47] = 32'h00000500;
    dig[0] = 32'h6A09E667; dig[1] = 32'hBB67AE85; dig[2] = 32'h3C6EF372; dig[3] = 32'hA54FF53A;
    dig[4] = 32'h510E527F; dig[5] = 32'h9B05688C; dig[6] = 32'h1F83D9AB; dig[7] = 32'h5BE0CD19;

    // hasher-port vectors applied during HASH; read data starts at RAM[0] from the START reads
    hv(1'b1, 16'd12,   32'hDEADBEEF, w[0],         1'b0);
    hv(1'b0, 16'd12,   32'h0,        32'hDEADBEEF, 1'b0);
    hv(1'b0, 16'd40,   32'h0,        32'h80000000, 1'b0);
    hv(1'b0, 16'd41,   32'h0,        32'h0,        1'b0);
    hv(1'b0, 16'd46,   32'h0,        32'h0,        1'b0);
    hv(1'b0, 16'd47,   32'h0,        32'h00000500, 1'b0);
    hv(1'b0, 16'd39,   32'h0,        w[39],        1'b0);
    for (int i = 0; i < 8; i++) hv(1'b1, 16'(1000 + i), dig[i], w[39], 1'b0);
    hv(1'b1, 16'd2048, 32'h0BADF00D, w[39],        1'b1);
    hv(1'b0, 16'hFFFF, 32'h0,        32'h0,        1'b1);
    hv(1'b0, 16'd0,    32'h0,        w[0],         1'b1);
    hv(1'b0, 16'd12,   32'h0,        32'hDEADBEEF, 1'b1);
    hv(1'b0, 16'd1003, 32'h0,        dig[3],       1'b1);

    step();
    step();
    chk("rst in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst out_data",  out_data,           32'd0);
    chk("rst out_last",  {31'd0, out_last},  32'd0);
    chk("rst busy",      {31'd0, busy},      32'd0);
    chk("rst error",     {31'd0, error},     32'd0);
    chk("rst sha_start", {31'd0, sha_start}, 32'd0);
    chk("rst rdata",     sha_mem_read_data,  32'd0);
    chk("msg addr",      {16'd0, sha_message_addr}, 32'd0);
    chk("out addr",      {16'd0, sha_output_addr},  32'd1000);
    reset_n = 1'b1;
    step();

    load_and_start("run1");
    chk("start read RAM0", sha_mem_read_data, w[0]);

    foreach (tbl[i]) begin
      sha_mem_we         = tbl[i].we;
      sha_mem_addr       = tbl[i].addr;
      sha_mem_write_data = tbl[i].wdata;
      step();
      chk($sformatf("hv[%0d] rdata", i), sha_mem_read_data, tbl[i].exp_rd);
      chk($sformatf("hv[%0d] error", i), {31'd0, error}, {31'd0, tbl[i].exp_err});
    end

    sha_mem_we   = 1'b0;
    sha_mem_addr = 16'd0;
    sha_done     = 1'b1;
    step();
    sha_done = 1'b0;

    for (int i = 0; i < 8; i++) begin
      n = 0;
      while (!out_valid && n < 10) begin
        step();
        n++;
      end
      chk($sformatf("beat%0d valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("beat%0d data", i), out_data, dig[i]);
      chk($sformatf("beat%0d last", i), {31'd0, out_last}, {31'd0, i == 7});
      if (i == 2) begin
        held = out_data;
        for (int k = 0; k < 5; k++) begin
          step();
          chk($sformatf("stall%0d valid", k), {31'd0, out_valid}, 32'd1);
          chk($sformatf("stall%0d data", k), out_data, held);
        end
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end
    chk("post unload in_ready", {31'd0, in_ready},  32'd1);
    chk("post unload busy",     {31'd0, busy},      32'd0);
    chk("post unload valid",    {31'd0, out_valid}, 32'd0);
    chk("post unload rdata",    sha_mem_read_data,  w[0]);
    chk("error sticky",         {31'd0, error},     32'd1);

    load_and_start("run2");
    in_valid = 1'b1;
    in_data  = 32'hFFFFFFFF;
    step();
    step();
    in_valid = 1'b0;
    chk("in_valid ignored in HASH", sha_mem_read_data, w[0]);
    chk("run2 busy in HASH",        {31'd0, busy},     32'd1);
    reset_n = 1'b0;
    step();
    chk("mid rst in_ready",  {31'd0, in_ready},  32'd1);
    chk("mid rst busy",      {31'd0, busy},      32'd0);
    chk("mid rst sha_start", {31'd0, sha_start}, 32'd0);
    chk("mid rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid rst error",     {31'd0, error},     32'd0);
    chk("mid rst rdata",     sha_mem_read_data,  32'd0);
    reset_n = 1'b1;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/sha256_host_bridge.md
# sha256_host_bridge

Memory-side responder and host front end for the `simplified_sha256` co-processor. It owns the word RAM the hasher reads its message from and writes its digest to, and answers the hasher's memory port with one-cycle read latency. Toward the host it accepts message words on a valid/ready stream, optionally appends SHA-256 padding, and pulses the hasher's start. It waits for done, then streams the 8 digest words back out.

## Interface
- NUM_OF_WORDS, 40, message length in 32-bit words (matches hasher parameter)
- DEPTH, 2048, RAM depth in words
- MSG_BASE, 0, RAM word address of message word 0, driven on sha_message_addr
- OUT_BASE, 1000, RAM word address of digest H0, driven on sha_output_addr
- clk  in  1  clock; hasher mem_clk must be this same clk
- reset_n  in  1  synchronous, active-low reset
- in_valid / in_ready  in / out  1 / 1  host message-word handshake
- in_data  in  32  message word
- out_valid / out_ready  out / in  1 / 1  digest-word handshake
- out_data  out  32  digest word
- out_last  out  1  high with H7
- busy  out  1  high in every state except LOAD
- error  out  1  sticky: hasher accessed address >= DEPTH
- sha_start  out  1  start to hasher
- sha_message_addr, sha_output_addr  out  16  constant MSG_BASE / OUT_BASE
- sha_done  in  1  hasher done
- sha_mem_we  in  1  hasher write enable
- sha_mem_addr  in  16  hasher word address
- sha_mem_write_data  in  32  hasher write data
- sha_mem_read_data  out  32  registered read data to hasher

## Operation
- Single-port RAM, one access per cycle. Bridge owns it in LOAD/PAD/RD/OUT; hasher owns it in START/HASH. Hasher accesses outside ownership: writes dropped, read data holds.
- LOAD: in_ready=1. Each accepted word is written to MSG_BASE+cnt, cnt++. After word NUM_OF_WORDS-1 -> PAD (or START without macro).
- PAD: one write per cycle, words NUM_OF_WORDS .. 16*B-1, where B=(NUM_OF_WORDS+2)/16+1 (integer division).
  - Word NUM_OF_WORDS = 32'h80000000.
  - Last word = NUM_OF_WORDS*32.
  - All others zero.
  - Then -> START.
- START: sha_start=1 for exactly 2 cycles -> HASH.
- HASH: wait for sha_done==1 (level-sampled) -> RD, cnt=0.
- RD: issue read of OUT_BASE+cnt -> OUT. OUT: out_valid=1, out_data=registered word, out_last=(cnt==7). On out_ready, cnt++; go to LOAD if cnt was 7, else RD.
- Hasher port, owner cycles, addr<DEPTH: we=1 writes at the clock edge. we=0 loads sha_mem_read_data at the edge. A write cycle leaves read data unchanged.
- Hasher port, addr>=DEPTH: write ignored, read returns 0, error<=1.
- sha_done outside HASH, and in_valid outside LOAD: ignored.
- Arithmetic: addresses computed in 16 bits, no wrap; parameters must satisfy MSG_BASE+16*B<=DEPTH and OUT_BASE+8<=DEPTH.

## Timing
- Reset values: state=LOAD, cnt=0, in_ready=1, out_valid=0, out_data=0, out_last=0, busy=0, error=0, sha_start=0, sha_mem_read_data=0. RAM contents are not cleared.
- Reset mid-operation returns to LOAD immediately; a hasher in progress must be reset by the same reset_n.
- Read latency 1 cycle: address at edge N, data valid after edge N+1.
- Host load: 1 word/cycle max.
- Digest unload: 2 cycles/word min; out_data stable while out_valid && !out_ready.
- LOAD-end to sha_start: 1 cycle plus the PAD length (16*B-NUM_OF_WORDS cycles, 8 for default).

## Configuration
- SHA_BRIDGE_AUTOPAD_EN defined: PAD state present; host sends exactly NUM_OF_WORDS words.
- SHA_BRIDGE_AUTOPAD_EN undefined: no PAD state; LOAD accepts 16*B words (host supplies padding) and then goes to START.

## Structure
- Package sha256_bridge_pkg holds:
  - state enum {LOAD, PAD, START, HASH, RD, OUT}
  - PAD_WORD = 32'h80000000
  - function num_blocks(n) = (n+2)/16+1
  - DIGEST_WORDS = 8
- Sub-module sha256_word_ram: single-port, synchronous write and registered read, parameter DEPTH.

## Test plan
- Reset, then load 40 words seeded 32'h01234675, each rotated left by 1 -> RAM[40]=32'h80000000, RAM[41..46]=0, RAM[47]=32'h00000500; sha_start high for 2 cycles.
- Hasher model writes 8 known words at 1000..1007 and raises done -> 8 out beats in order, out_last only on the 8th, then in_ready=1.
- out_ready held low for 5 cycles on beat 3 -> out_data stable, no word lost or repeated.
- Hasher read of address 12 after write 32'hDEADBEEF -> sha_mem_read_data=32'hDEADBEEF one cycle later; read of 16'hFFFF -> data 0, error=1 and sticky.
- reset_n low during HASH -> next cycle state LOAD, sha_start=0, out_valid=0, error=0.
- Macro undefined: host sends 48 words -> no PAD writes; sha_start follows word 48 by 1 cycle.
